decode_queue: RTL and testbench
===============================

DECODE_QUEUE -- requirements
Module: decode_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 2, number of buffered decoded bundles; power of two, at least 2.
REQ-002 SHALL have parameter REG_ADDR_W, default 4, register address width, at most 4.
REQ-003 SHALL have ports: clk input 1, rising-edge clock; reset input 1, synchronous, active-high.
REQ-004 SHALL have ports: instr_valid input 1, instruction offered; instr_ready output 1, queue can accept; instruction input 16, raw instruction word.
REQ-005 SHALL have ports: flush input 1, discards all queued bundles; dec_valid output 1, head bundle valid; dec_ready input 1, consumer takes head.
REQ-006 SHALL have ports: dec_rd, dec_rs, dec_rt outputs REG_ADDR_W each, register addresses; dec_nzp output 3, branch condition; dec_imm output 8, immediate.
REQ-007 SHALL have ports: dec_reg_we, dec_mem_re, dec_mem_we, dec_nzp_we, dec_alu_out_mux, dec_pc_mux, dec_ret, dec_illegal, each output 1.
REQ-008 SHALL have ports: dec_reg_in_mux output 2, register write source; dec_alu_arith_mux output 3, ALU operation; count output clog2(DEPTH)+1, occupancy.

Function
REQ-009 SHALL accept an instruction on a rising edge where instr_valid and instr_ready are both 1 and flush is 0.
REQ-010 SHALL drive instr_ready to 1 exactly when count is less than DEPTH; instr_ready SHALL NOT depend on dec_ready, so there is no bypass when full.
REQ-011 SHALL decode fields on accept and store them as a bundle in a FIFO entry:
- rd = instruction[8 +: REG_ADDR_W]
- rs = instruction[4 +: REG_ADDR_W]
- rt = instruction[0 +: REG_ADDR_W]
- nzp = instruction[11:9]
- imm = instruction[7:0]
REQ-012 SHALL derive control bits from opcode instruction[15:12]; every bit not listed defaults to 0:
- 0000 NOP: none
- 0001 BR: pc_mux=1
- 0010 CMP: alu_out_mux=1, nzp_we=1
- 0011 ADD: reg_we=1, arith=000
- 0100 SUB: reg_we=1, arith=001
- 0101 MUL: reg_we=1, arith=010
- 0110 DIV: reg_we=1, arith=011
- 0111 LDR: reg_we=1, mem_re=1, reg_in_mux=01
- 1000 STR: mem_we=1
- 1001 CONST: reg_we=1, reg_in_mux=10
- 1111 RET: ret=1
REQ-013 SHALL decode every other opcode as illegal: illegal=1 and all enables, ret and pc_mux 0; field outputs still decoded.
REQ-014 SHALL present the head bundle combinationally on the dec_* outputs; dec_valid = (count != 0).
REQ-015 SHALL pop the head on a rising edge where dec_valid and dec_ready are both 1 and flush is 0.
REQ-016 SHALL make an accepted instruction visible at the outputs no earlier than the cycle after acceptance, giving 1-cycle minimum latency.
REQ-017 SHALL allow push and pop in the same cycle when 0 < count < DEPTH; count is then unchanged and order is preserved.
REQ-018 SHALL hold the head bundle stable while dec_valid=1 and dec_ready=0.
REQ-019 SHALL, on flush=1, empty the queue at the next edge (count=0, pointers reset); flush SHALL take priority over a simultaneous push and pop, and the offered instruction is dropped.
REQ-020 SHALL wrap read and write pointers modulo DEPTH.
REQ-021 SHALL ignore dec_ready while empty and instr_valid while full, with no state change.

Reset
REQ-022 SHALL, when reset=1 at a rising edge, set count=0 and both pointers to 0; reset SHALL take priority over flush, push and pop.
REQ-023 SHALL drive dec_valid=0 and instr_ready=1 in the cycle after reset, and all dec_* outputs to 0 while empty.
REQ-024 SHALL discard any in-flight contents on a mid-operation reset, with no partial bundle surviving.

Configuration
REQ-025 SHALL, when DECODE_QUEUE_EXT_ALU_EN is defined, decode the following as legal, each with reg_we=1 and reg_in_mux=00:
- 1010 AND: arith=100
- 1011 OR: arith=101
- 1100 XOR: arith=110
REQ-026 SHALL, when DECODE_QUEUE_EXT_ALU_EN is undefined, treat 1010, 1011 and 1100 as illegal per REQ-013; the port list is identical in both builds.

Verification
REQ-027 SHALL cover: reset, then push 0x3123 (ADD) -> next cycle dec_valid=1, rd=1, rs=2, rt=3, reg_we=1, arith=000, count=1.
REQ-028 SHALL cover: DEPTH=2, dec_ready=0, push three instructions -> third push stalled, instr_ready=0 at count=2, first bundle stable.
REQ-029 SHALL cover: count=1 with simultaneous push 0x9207 and pop -> count stays 1; next head is CONST with rd=2, imm=0x07, reg_in_mux=10.
REQ-030 SHALL cover: queue full, flush=1 with instr_valid=1 -> count=0, dec_valid=0 next cycle, offered instruction absent.
REQ-031 SHALL cover: push 0xA123 -> with macro: reg_we=1, arith=100, illegal=0; without macro: illegal=1, reg_we=0.
REQ-032 SHALL cover: push 0xF000, then reset asserted while valid -> dec_valid=0 and count=0 after the reset edge; before reset, dec_ret=1.

Source files
------------

// File: rtl/decode_queue_if.sv
// Handshake and decoded-bundle signals between the instruction source, decode_queue and its consumer.
interface decode_queue_if #(
  parameter int DEPTH      = 2,
  parameter int REG_ADDR_W = 4
);
  logic                     instr_valid;
  logic                     instr_ready;
  logic [15:0]              instruction;
  logic                     flush;
  logic                     dec_valid;
  logic                     dec_ready;
  logic [REG_ADDR_W-1:0]    dec_rd;
  logic [REG_ADDR_W-1:0]    dec_rs;
  logic [REG_ADDR_W-1:0]    dec_rt;
  logic [2:0]               dec_nzp;
  logic [7:0]               dec_imm;
  logic                     dec_reg_we;
  logic                     dec_mem_re;
  logic                     dec_mem_we;
  logic                     dec_nzp_we;
  logic                     dec_alu_out_mux;
  logic                     dec_pc_mux;
  logic                     dec_ret;
  logic                     dec_illegal;
  logic [1:0]               dec_reg_in_mux;
  logic [2:0]               dec_alu_arith_mux;
  logic [$clog2(DEPTH):0]   count;

  modport master (
    output instr_valid, instruction, flush, dec_ready,
    input  instr_ready, dec_valid, dec_rd, dec_rs, dec_rt, dec_nzp, dec_imm,
           dec_reg_we, dec_mem_re, dec_mem_we, dec_nzp_we, dec_alu_out_mux,
           dec_pc_mux, dec_ret, dec_illegal, dec_reg_in_mux, dec_alu_arith_mux, count
  );

  modport slave (
    input  instr_valid, instruction, flush, dec_ready,
    output instr_ready, dec_valid, dec_rd, dec_rs, dec_rt, dec_nzp, dec_imm,
           dec_reg_we, dec_mem_re, dec_mem_we, dec_nzp_we, dec_alu_out_mux,
           dec_pc_mux, dec_ret, dec_illegal, dec_reg_in_mux, dec_alu_arith_mux, count
  );
endinterface

// File: rtl/decode_queue.sv
// Decodes 16-bit instructions on accept and buffers the bundles in a DEPTH-entry FIFO.
// Define DECODE_QUEUE_EXT_ALU_EN to make AND/OR/XOR (opcodes 1010/1011/1100) legal.
module decode_queue #(
  parameter int DEPTH      = 2,
  parameter int REG_ADDR_W = 4
) (
  input  logic           clk,
  input  logic           reset,
  decode_queue_if.slave  q
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  generate
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("decode_queue: DEPTH must be a power of two, at least 2");
    end
    if (REG_ADDR_W < 1 || REG_ADDR_W > 4) begin : g_bad_addr_w
      $error("decode_queue: REG_ADDR_W must be between 1 and 4");
    end
  endgenerate

  typedef enum logic [3:0] {
    OP_NOP   = 4'b0000,
    OP_BR    = 4'b0001,
    OP_CMP   = 4'b0010,
    OP_ADD   = 4'b0011,
    OP_SUB   = 4'b0100,
    OP_MUL   = 4'b0101,
    OP_DIV   = 4'b0110,
    OP_LDR   = 4'b0111,
    OP_STR   = 4'b1000,
    OP_CONST = 4'b1001,
    OP_AND   = 4'b1010,
    OP_OR    = 4'b1011,
    OP_XOR   = 4'b1100,
    OP_RET   = 4'b1111
  } opcode_e;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [REG_ADDR_W-1:0] rs;
    logic [REG_ADDR_W-1:0] rt;
    logic [2:0]            nzp;
    logic [7:0]            imm;
    logic                  reg_we;
    logic                  mem_re;
    logic                  mem_we;
    logic                  nzp_we;
    logic                  alu_out_mux;
    logic                  pc_mux;
    logic                  ret;
    logic                  illegal;
    logic [1:0]            reg_in_mux;
    logic [2:0]            arith;
  } bundle_t;

  bundle_t           mem [DEPTH];
  bundle_t           dec_in;
  bundle_t           head;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  cnt;
  logic              push;
  logic              pop;
  logic              not_empty;
  logic [3:0]        opcode;

  assign opcode    = q.instruction[15:12];
  assign not_empty = (cnt != '0);
  assign push      = q.instr_valid && q.instr_ready && !q.flush;
  assign pop       = not_empty && q.dec_ready && !q.flush;

  always_comb begin
    dec_in       = '0;
    dec_in.rd    = q.instruction[8 +: REG_ADDR_W];
    dec_in.rs    = q.instruction[4 +: REG_ADDR_W];
    dec_in.rt    = q.instruction[0 +: REG_ADDR_W];
    dec_in.nzp   = q.instruction[11:9];
    dec_in.imm   = q.instruction[7:0];
    case (opcode)
      OP_NOP:   ;
      OP_BR:    dec_in.pc_mux = 1'b1;
      OP_CMP: begin
        dec_in.alu_out_mux = 1'b1;
        dec_in.nzp_we      = 1'b1;
      end
      OP_ADD: begin
        dec_in.reg_we = 1'b1;
        dec_in.arith  = 3'b000;
      end
      OP_SUB: begin
        dec_in.reg_we = 1'b1;
        dec_in.arith  = 3'b001;
      end
      OP_MUL: begin
        dec_in.reg_we = 1'b1;
        dec_in.arith  = 3'b010;
      end
      OP_DIV: begin
        dec_in.reg_we = 1'b1;
        dec_in.arith  = 3'b011;
      end
      OP_LDR: begin
        dec_in.reg_we     = 1'b1;
        dec_in.mem_re     = 1'b1;
        dec_in.reg_in_mux = 2'b01;
      end
      OP_STR:   dec_in.mem_we = 1'b1;
      OP_CONST: begin
        dec_in.reg_we     = 1'b1;
        dec_in.reg_in_mux = 2'b10;
      end
      OP_RET:   dec_in.ret = 1'b1;
`ifdef DECODE_QUEUE_EXT_ALU_EN
      OP_AND: begin
        dec_in.reg_we = 1'b1;
        dec_in.arith  = 3'b100;
      end
      OP_OR: begin
        dec_in.reg_we = 1'b1;
        dec_in.arith  = 3'b101;
      end
      OP_XOR: begin
        dec_in.reg_we = 1'b1;
        dec_in.arith  = 3'b110;
      end
`endif
      default:  dec_in.illegal = 1'b1;
    endcase
  end

  // Storage needs no reset: the head is masked to zero whenever the queue is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= dec_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || q.flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push && !pop) begin
        cnt <= cnt + CNT_W'(1);
      end else if (pop && !push) begin
        cnt <= cnt - CNT_W'(1);
      end
    end
  end

  always_comb begin
    head = '0;
    if (not_empty) begin
      head = mem[rd_ptr];
    end
  end

  assign q.instr_ready       = (cnt < FULL_CNT);
  assign q.dec_valid         = not_empty;
  assign q.count             = cnt;
  assign q.dec_rd            = head.rd;
  assign q.dec_rs            = head.rs;
  assign q.dec_rt            = head.rt;
  assign q.dec_nzp           = head.nzp;
  assign q.dec_imm           = head.imm;
  assign q.dec_reg_we        = head.reg_we;
  assign q.dec_mem_re        = head.mem_re;
  assign q.dec_mem_we        = head.mem_we;
  assign q.dec_nzp_we        = head.nzp_we;
  assign q.dec_alu_out_mux   = head.alu_out_mux;
  assign q.dec_pc_mux        = head.pc_mux;
  assign q.dec_ret           = head.ret;
  assign q.dec_illegal       = head.illegal;
  assign q.dec_reg_in_mux    = head.reg_in_mux;
  assign q.dec_alu_arith_mux = head.arith;

endmodule

// File: tb/tb_decode_queue.sv
// Scoreboard bench for decode_queue: reference decode pushed on accept, compared at the head and on pop.
module tb_decode_queue;

  localparam int DEPTH      = 2;
  localparam int REG_ADDR_W = 4;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  logic [35:0] mq[$];

  decode_queue_if #(.DEPTH(DEPTH), .REG_ADDR_W(REG_ADDR_W)) dq ();

  decode_queue #(.DEPTH(DEPTH), .REG_ADDR_W(REG_ADDR_W)) dut (
    .clk   (clk),
    .reset (reset),
    .q     (dq.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // {rd,rs,rt,nzp,imm,reg_we,mem_re,mem_we,nzp_we,alu_out_mux,pc_mux,ret,illegal,reg_in_mux,arith}
  function automatic logic [35:0] ref_dec(input logic [15:0] i);
    logic [7:0] c;
    logic [1:0] rim;
    logic [2:0] ar;
    c = '0; rim = '0; ar = '0;
    case (i[15:12])
      4'h0: ;
      4'h1: c[2] = 1'b1;
      4'h2: begin c[3] = 1'b1; c[4] = 1'b1; end
      4'h3: begin c[7] = 1'b1; ar = 3'd0; end
      4'h4: begin c[7] = 1'b1; ar = 3'd1; end
      4'h5: begin c[7] = 1'b1; ar = 3'd2; end
      4'h6: begin c[7] = 1'b1; ar = 3'd3; end
      4'h7: begin c[7] = 1'b1; c[6] = 1'b1; rim = 2'b01; end
      4'h8: c[5] = 1'b1;
      4'h9: begin c[7] = 1'b1; rim = 2'b10; end
      4'hF: c[1] = 1'b1;
`ifdef DECODE_QUEUE_EXT_ALU_EN
      4'hA: begin c[7] = 1'b1; ar = 3'd4; end
      4'hB: begin c[7] = 1'b1; ar = 3'd5; end
      4'hC: begin c[7] = 1'b1; ar = 3'd6; end
`endif
      default: c[0] = 1'b1;
    endcase
    return {i[11:8], i[7:4], i[3:0], i[11:9], i[7:0], c, rim, ar};
  endfunction

  function automatic logic [35:0] dut_bundle();
    return {dq.dec_rd, dq.dec_rs, dq.dec_rt, dq.dec_nzp, dq.dec_imm,
            dq.dec_reg_we, dq.dec_mem_re, dq.dec_mem_we, dq.dec_nzp_we,
            dq.dec_alu_out_mux, dq.dec_pc_mux, dq.dec_ret, dq.dec_illegal,
            dq.dec_reg_in_mux, dq.dec_alu_arith_mux};
  endfunction

  task automatic cycle(input logic rst, input logic v, input logic [15:0] ins,
                       input logic rdy, input logic fl);
    logic push, pop;
    logic [35:0] exp_b;
    reset          = rst;
    dq.instr_valid = v;
    dq.instruction = ins;
    dq.dec_ready   = rdy;
    dq.flush       = fl;
    #1;
    check("instr_ready", 64'(dq.instr_ready), 64'(mq.size() < DEPTH));
    push = !rst && !fl && v && (mq.size() < DEPTH);
    pop  = !rst && !fl && rdy && (mq.size() > 0);
    if (pop) begin
      exp_b = mq.pop_front();
      check("pop_bundle", 64'(dut_bundle()), 64'(exp_b));
    end
    @(posedge clk);
    #1;
    if (rst || fl) mq.delete();
    else if (push) mq.push_back(ref_dec(ins));
    check("count", 64'(dq.count), 64'(mq.size()));
    check("dec_valid", 64'(dq.dec_valid), 64'(mq.size() != 0));
    check("head", 64'(dut_bundle()), (mq.size() != 0) ? 64'(mq[0]) : 64'd0);
  endtask

  initial begin
    logic [35:0] first_head;
    reset = 1'b1; dq.instr_valid = 1'b0; dq.instruction = '0;
    dq.dec_ready = 1'b0; dq.flush = 1'b0;
    cycle(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
    // reset wins over simultaneous push and flush
    cycle(1'b1, 1'b1, 16'h3123, 1'b1, 1'b1);
    check("rst_ready", 64'(dq.instr_ready), 64'd1);
    check("rst_empty_bundle", 64'(dut_bundle()), 64'd0);

    // single ADD, visible next cycle
    cycle(1'b0, 1'b1, 16'h3123, 1'b0, 1'b0);
    check("add_rd", 64'(dq.dec_rd), 64'd1);
    check("add_rs", 64'(dq.dec_rs), 64'd2);
    check("add_rt", 64'(dq.dec_rt), 64'd3);
    check("add_we", 64'(dq.dec_reg_we), 64'd1);
    check("add_arith", 64'(dq.dec_alu_arith_mux), 64'd0);
    check("add_count", 64'(dq.count), 64'd1);
    first_head = dut_bundle();

    // fill, then stalled third push with head stable
    cycle(1'b0, 1'b1, 16'h4456, 1'b0, 1'b0);
    check("full_ready", 64'(dq.instr_ready), 64'd0);
    cycle(1'b0, 1'b1, 16'h7ABC, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 16'h7ABC, 1'b0, 1'b0);
    check("stall_head", 64'(dut_bundle()), 64'(first_head));
    check("stall_count", 64'(dq.count), 64'd2);

    // pop to one, then simultaneous push CONST and pop
    cycle(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 16'h9207, 1'b1, 1'b0);
    check("pp_count", 64'(dq.count), 64'd1);
    check("pp_rd", 64'(dq.dec_rd), 64'd2);
    check("pp_imm", 64'(dq.dec_imm), 64'h07);
    check("pp_rim", 64'(dq.dec_reg_in_mux), 64'd2);

    // fill then flush with an offered instruction
    cycle(1'b0, 1'b1, 16'h1E55, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 16'h2345, 1'b1, 1'b1);
    check("flush_valid", 64'(dq.dec_valid), 64'd0);
    check("flush_count", 64'(dq.count), 64'd0);
    cycle(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);

    // extension opcodes and other illegal/legal encodings
    cycle(1'b0, 1'b1, 16'hA123, 1'b0, 1'b0);
`ifdef DECODE_QUEUE_EXT_ALU_EN
    check("ext_we", 64'(dq.dec_reg_we), 64'd1);
    check("ext_arith", 64'(dq.dec_alu_arith_mux), 64'd4);
    check("ext_illegal", 64'(dq.dec_illegal), 64'd0);
`else
    check("ext_we", 64'(dq.dec_reg_we), 64'd0);
    check("ext_illegal", 64'(dq.dec_illegal), 64'd1);
`endif
    foreach (mq[k]) ;
    for (int unsigned op = 0; op < 16; op++) begin
      cycle(1'b0, 1'b1, {op[3:0], 12'hB5C}, 1'b1, 1'b0);
    end
    cycle(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);

    // RET then mid-operation reset
    cycle(1'b0, 1'b1, 16'hF000, 1'b0, 1'b0);
    check("ret_bit", 64'(dq.dec_ret), 64'd1);
    cycle(1'b0, 1'b1, 16'h5321, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 16'h6111, 1'b1, 1'b0);
    check("rst_mid_valid", 64'(dq.dec_valid), 64'd0);
    check("rst_mid_count", 64'(dq.count), 64'd0);

    // random traffic
    for (int n = 0; n < 400; n++) begin
      cycle($urandom_range(0, 59) == 0, $urandom_range(0, 3) != 0,
            16'($urandom()), $urandom_range(0, 2) != 0, $urandom_range(0, 24) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
